// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the LEGv8 pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int                REG_AW   = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Destination view of an in-flight instruction, kept for EX, MEM and WB.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    // Source view of the instruction in EX, needed to pick forwarding paths.
    typedef struct packed {
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
        logic              use_rn;
        logic              use_rm;
    } ex_src_t;

endpackage

// File: rtl/pipe_dep_check.sv
// rtl/pipe_dep_check.sv - RAW dependency compare of one source register against one shadow stage
module pipe_dep_check #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  logic              v,
    input  logic [REG_AW-1:0] rd,
    input  logic              regwrite,
    output logic              dep
);

    localparam logic [REG_AW-1:0] XZR = REG_AW'(ZERO_REG);

    // XZR reads as zero and discards writes, so it can never carry a dependency.
    assign dep = use_src & v & regwrite & (src == rd) & (src != XZR);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush/forwarding controller; PIPE_FWD_EN enables EX forwarding
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              mem_br_taken,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_ctrl_pkg::*;

    stage_t  ex_q, mem_q, wb_q;
    stage_t  ex_d, mem_d;
    ex_src_t ex_src_q, ex_src_d;

    logic dep_rn_ex, dep_rm_ex;
    logic hazard;
    logic stall;
    logic unused_state;

    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_rn_ex (
        .src(id_rn), .use_src(id_use_rn), .v(ex_q.v), .rd(ex_q.rd),
        .regwrite(ex_q.regwrite), .dep(dep_rn_ex)
    );
    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_rm_ex (
        .src(id_rm), .use_src(id_use_rm), .v(ex_q.v), .rd(ex_q.rd),
        .regwrite(ex_q.regwrite), .dep(dep_rm_ex)
    );

`ifdef PIPE_FWD_EN
    logic dep_a_mem, dep_b_mem, dep_a_wb, dep_b_wb;

    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_a_mem (
        .src(ex_src_q.rn), .use_src(ex_src_q.use_rn & ex_q.v), .v(mem_q.v), .rd(mem_q.rd),
        .regwrite(mem_q.regwrite), .dep(dep_a_mem)
    );
    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_b_mem (
        .src(ex_src_q.rm), .use_src(ex_src_q.use_rm & ex_q.v), .v(mem_q.v), .rd(mem_q.rd),
        .regwrite(mem_q.regwrite), .dep(dep_b_mem)
    );
    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_a_wb (
        .src(ex_src_q.rn), .use_src(ex_src_q.use_rn & ex_q.v), .v(wb_q.v), .rd(wb_q.rd),
        .regwrite(wb_q.regwrite), .dep(dep_a_wb)
    );
    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_b_wb (
        .src(ex_src_q.rm), .use_src(ex_src_q.use_rm & ex_q.v), .v(wb_q.v), .rd(wb_q.rd),
        .regwrite(wb_q.regwrite), .dep(dep_b_wb)
    );

    // Only a load still in EX has no result to forward yet.
    assign hazard = (dep_rn_ex | dep_rm_ex) & ex_q.memread;

    // The newest producer (MEM) takes priority over the older one (WB).
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (dep_a_mem)     fwd_a = FWD_MEM;
        else if (dep_a_wb) fwd_a = FWD_WB;
        if (dep_b_mem)     fwd_b = FWD_MEM;
        else if (dep_b_wb) fwd_b = FWD_WB;
    end

    assign unused_state = ^{mem_q.memread, wb_q.memread};
`else
    logic dep_rn_mem, dep_rm_mem;

    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_rn_mem (
        .src(id_rn), .use_src(id_use_rn), .v(mem_q.v), .rd(mem_q.rd),
        .regwrite(mem_q.regwrite), .dep(dep_rn_mem)
    );
    pipe_dep_check #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_dep_rm_mem (
        .src(id_rm), .use_src(id_use_rm), .v(mem_q.v), .rd(mem_q.rd),
        .regwrite(mem_q.regwrite), .dep(dep_rm_mem)
    );

    // Without forwarding every producer in EX or MEM must reach the write-through register file.
    assign hazard = dep_rn_ex | dep_rm_ex | dep_rn_mem | dep_rm_mem;
    assign fwd_a  = FWD_REG;
    assign fwd_b  = FWD_REG;

    assign unused_state = ^{ex_q.memread, mem_q.memread, wb_q, ex_src_q};
`endif

    // A taken branch squashes the ID instruction anyway, so it overrides any stall.
    assign stall     = id_valid & ~mem_br_taken & hazard;
    assign stall_if  = stall;
    assign bubble_ex = stall;
    assign flush     = mem_br_taken;

    // Next shadow contents: EX takes ID unless bubbled or flushed; flush also kills what enters MEM.
    always_comb begin
        ex_d     = '{v: id_valid & ~stall & ~mem_br_taken, rd: id_rd,
                     regwrite: id_regwrite, memread: id_memread};
        ex_src_d = '{rn: id_rn, rm: id_rm, use_rn: id_use_rn, use_rm: id_use_rm};
        mem_d    = ex_q;
        mem_d.v  = ex_q.v & ~mem_br_taken;
    end

    // Shadow scoreboard advances on the pipeline's falling edge.
    always_ff @(negedge CLK) begin
        if (resetl) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_src_q <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_src_q <= ex_src_d;
            mem_q    <= mem_d;
            wb_q     <= mem_q;
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_ff @(negedge CLK) begin
        if (resetl) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
